// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_arbiter_pkg;

    localparam int unsigned CLKS_PER_BIT_100M_115200 = 868;
    localparam int unsigned DATA_W_DEF               = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_HOLD
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus uart_tx control/status, bundled for the arbiter.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_byte;
    logic                      tx_active;
    logic                      tx_done;

    modport master (
        output req_valid, req_data, req_last, tx_active, tx_done,
        input  req_ready, tx_start, tx_byte
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_active, tx_done,
        output req_ready, tx_start, tx_byte
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module uart_tx_arbiter_rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int unsigned cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                         = 1'b1;
                grant_idx                   = cand[IDX_W-1:0];
                grant_oh[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources,
// holding the transmitter for a whole packet up to its last byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned LOCK_TIMEOUT = 4096,
    localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               lock_tmo
);

    localparam int unsigned TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              last_q, last_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0] ready_c;
    logic               start_c;
    logic               tmo_c;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  src_byte [NUM_REQ];
    logic [IDX_W-1:0]   grant_next;

    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            src_byte[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign grant_next = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

    // ready is gated by rst so no byte is accepted in a cycle whose state is discarded
    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        tmo_cnt_d   = tmo_cnt_q;
        ready_c     = '0;
        start_c     = 1'b0;
        tmo_c       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rst && !bus.tx_active && pick_any) begin
                    ready_c     = pick_oh;
                    tx_byte_d   = src_byte[pick_idx];
                    grant_idx_d = pick_idx;
                    last_d      = bus.req_last[pick_idx];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_c = 1'b1;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (last_q) begin
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!rst && bus.req_valid[grant_idx_q]) begin
                    ready_c[grant_idx_q] = 1'b1;
                    tx_byte_d            = src_byte[grant_idx_q];
                    last_d               = bus.req_last[grant_idx_q];
                    state_d              = ST_ISSUE;
                end else if (LOCK_TIMEOUT != 0 && tmo_cnt_q == TMO_LAST) begin
                    tmo_c    = 1'b1;
                    rr_ptr_d = grant_next;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_byte_q   <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            last_q      <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_byte_q   <= tx_byte_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.tx_start  = start_c;
    assign bus.tx_byte   = tx_byte_q;
    assign grant_idx     = grant_idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign lock_tmo      = tmo_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: queued sources, behavioural uart_tx + line decoder, round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned LT  = 16;
    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    logic [1:0] grant_idx;
    logic       busy;
    logic       lock_tmo;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_idx (grant_idx),
        .busy      (busy),
        .lock_tmo  (lock_tmo)
    );

    typedef struct { logic [7:0] d; logic last; } beat_t;
    typedef struct { int unsigned src; logic [7:0] d; } exp_t;

    beat_t       drv_q [NR][$];
    beat_t       mdl_q [NR][$];
    exp_t        exp_q [$];
    logic [7:0]  line_q [$];
    int unsigned mdl_ptr = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    longint unsigned cyc = 0;
    longint unsigned done_cyc = 0;
    int          n_tmo = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source drivers: head of each queue is presented until accepted
    logic [NR-1:0] xfer_n = '0;
    always @(negedge clk) xfer_n = bus.req_valid & bus.req_ready;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (xfer_n[i] && drv_q[i].size() != 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() != 0) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*DW +: DW] = drv_q[i][0].d;
                    bus.req_last[i]          = drv_q[i][0].last;
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- behavioural uart_tx (not reset by rst, like the real block)
    logic        u_active = 1'b0;
    logic        u_done   = 1'b0;
    int unsigned u_cyc    = 0;
    logic [7:0]  u_sh     = '0;
    logic        tx_line;

    always @(posedge clk) begin
        u_done <= 1'b0;
        if (!u_active) begin
            if (bus.tx_start) begin
                u_active <= 1'b1;
                u_sh     <= bus.tx_byte;
                u_cyc    <= 0;
            end
        end else if (u_cyc == 10*CPB - 1) begin
            u_active <= 1'b0;
            u_done   <= 1'b1;
        end else begin
            u_cyc <= u_cyc + 1;
        end
    end

    assign bus.tx_active = u_active;
    assign bus.tx_done   = u_done;

    always_comb begin
        tx_line = 1'b1;
        if (u_active) begin
            if (u_cyc / CPB == 0)      tx_line = 1'b0;
            else if (u_cyc / CPB == 9) tx_line = 1'b1;
            else                       tx_line = u_sh[u_cyc / CPB - 1];
        end
    end

    // ---------------- serial line decoder
    logic [7:0] rx_b;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                repeat (CPB + 1) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    rx_b[k] = tx_line;
                    if (k < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                check("stop_bit", tx_line, 1);
                if (line_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL line_byte: got %0h with nothing expected", rx_b);
                end else begin
                    check("line_byte", rx_b, line_q.pop_front());
                end
            end
        end
    end

    // ---------------- tx_start / handshake monitor
    logic xfer_prev = 1'b0;
    exp_t e_head;
    always @(negedge clk) begin
        cyc++;
        if (bus.req_ready != '0) check("ready_onehot", $countones(bus.req_ready), 1);
        if (bus.tx_start || xfer_prev) check("start_latency", bus.tx_start, xfer_prev);
        if (bus.tx_start) begin
            check("start_uart_idle", u_active, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_start: got byte %0h from src %0d with nothing expected", bus.tx_byte, grant_idx);
            end else begin
                e_head = exp_q.pop_front();
                check("tx_byte", bus.tx_byte, e_head.d);
                check("grant_idx", grant_idx, e_head.src);
            end
        end
        if (bus.tx_done) done_cyc = cyc;
        if (lock_tmo) begin
            n_tmo++;
            check("tmo_delay", cyc - done_cyc, 17);
        end
        xfer_prev = !rst && (|(bus.req_valid & bus.req_ready));
    end

    // ---------------- reference model: sources loaded together are served packet by packet
    task automatic load(int s, logic [7:0] d, logic last);
        drv_q[s].push_back('{d, last});
        mdl_q[s].push_back('{d, last});
    endtask

    task automatic run_model();
        bit    found;
        beat_t b;
        do begin
            found = 0;
            for (int off = 0; off < NR; off++) begin
                int s;
                s = (int'(mdl_ptr) + off) % NR;
                if (!found && mdl_q[s].size() != 0) begin
                    do begin
                        b = mdl_q[s].pop_front();
                        exp_q.push_back('{s, b.d});
                        line_q.push_back(b.d);
                    end while (!b.last && mdl_q[s].size() != 0);
                    mdl_ptr = (s + 1) % NR;
                    found   = 1;
                end
            end
        end while (found);
    endtask

    task automatic wait_drain();
        int  quiet;
        bit  empty;
        quiet = 0;
        for (int i = 0; i < 6000 && quiet < 3; i++) begin
            @(negedge clk);
            empty = 1;
            for (int s = 0; s < NR; s++) if (drv_q[s].size() != 0) empty = 0;
            if (empty && !busy && !u_active && exp_q.size() == 0 && line_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check("drain_in_time", quiet >= 3, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_byte", bus.tx_byte, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_lock_tmo", lock_tmo, 0);
        mdl_ptr = 0;
        rst = 1'b0;
    endtask

    initial begin
        int tmo0;
        repeat (3) @(negedge clk);
        do_reset();

        // single source, single-byte packet
        load(0, 8'hA5, 1'b1);
        run_model();
        @(negedge clk);
        check("t1_ready", bus.req_ready, 4'b0001);
        check("t1_busy_idle", busy, 0);
        @(negedge clk);
        check("t1_tx_start", bus.tx_start, 1);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_start_pulse", bus.tx_start, 0);
        wait_drain();

        // round robin from pointer 0, src0 has a second packet
        do_reset();
        for (int s = 0; s < NR; s++) load(s, 8'h10 + 8'(s), 1'b1);
        load(0, 8'hF0, 1'b1);
        run_model();
        wait_drain();

        // packet lock: src1 three bytes, src2 waiting
        load(1, 8'h11, 1'b0);
        load(1, 8'h22, 1'b0);
        load(1, 8'h33, 1'b1);
        load(2, 8'h44, 1'b1);
        run_model();
        wait_drain();

        // lock timeout: src0 packet never terminates
        tmo0 = n_tmo;
        load(0, 8'h01, 1'b0);
        load(1, 8'h77, 1'b1);
        run_model();
        wait_drain();
        check("lock_tmo_count", n_tmo - tmo0, 1);

        // reset mid-frame
        load(2, 8'h5A, 1'b1);
        run_model();
        for (int i = 0; i < 100 && !bus.tx_start; i++) @(negedge clk);
        repeat (18) @(negedge clk);
        check("t5_mid_frame", u_active, 1);
        rst = 1'b1;
        load(2, 8'hC3, 1'b1);
        load(3, 8'h3C, 1'b1);
        mdl_ptr = 0;
        run_model();
        repeat (2) @(negedge clk);
        check("t5_rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_active_still", u_active, 1);
        check("t5_hold_off_ready", bus.req_ready, 0);
        check("t5_hold_off_start", bus.tx_start, 0);
        wait_drain();

        // wrap: pointer 3 with src3 and src0 pending
        load(2, 8'h99, 1'b1);
        run_model();
        wait_drain();
        load(3, 8'hD3, 1'b1);
        load(0, 8'hD0, 1'b1);
        run_model();
        wait_drain();

        // randomized rounds
        for (int r = 0; r < 25; r++) begin
            for (int s = 0; s < NR; s++) begin
                int np;
                np = int'($urandom_range(0, 2));
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = int'($urandom_range(1, 3));
                    for (int k = 0; k < len; k++) load(s, 8'($urandom), k == len - 1);
                end
            end
            run_model();
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
